core18_cpu: RTL and testbench
=============================

Name: core18_cpu

Overview:
- 18-bit single-issue microcontroller core; executes one instruction per CLK.
- Fetches from an external asynchronous instruction ROM through PC/INST.
- Accesses external RAM, constant ROM and I/O ports through a shared ADRS/DATAIN/DATAOUT bus.
- Provides prioritized single-level interrupts via VECTOR and a LEVEL mask, plus 64 general-purpose bit outputs.

Parameters:
- NREG, 64, number of 18-bit registers; the register field is 6 bits.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-high reset
- RUN  in  1  1 = execute; 0 = hold core idle with PC at 0
- INST  in  18  instruction at PC, combinational from ROM
- VECTOR  in  4  interrupt request; 0 = none
- DATAIN  in  18  read data (RAM, constant or port), combinational
- BITSIN  in  64  testable input bits
- BITSOUT  out  64  bit-output register
- CONST_RD  out  1  constant-ROM read strobe
- PORT_RD  out  1  port read strobe
- PORT_WR  out  1  port write strobe
- RAM_WR  out  1  RAM write strobe
- RESET  out  1  peripheral reset, = RST | ~RUN
- DATAOUT  out  18  write data
- ADRS  out  18  data address
- PC  out  12  program counter

Behaviour:
- Reset (RST high, async): PC=0, LEVEL=0, Z=0, halted=0, in_isr=0, BITSOUT=0, all strobes 0. Registers are not reset.
- RUN=0: no state changes; PC forced to 0; strobes 0.
- Strobes, ADRS and DATAOUT are combinational from INST and registers; their effects commit on the rising edge.
- Encoding: op=INST[17:15], sub=INST[14:12], a=INST[11:6], r=INST[5:0].
- op0 system group, selected by INST[11:6]:
  - 00 NOP.
  - 01 HALT: PC<=PC+1, halted<=1; no fetch until an interrupt is taken.
  - 02 SETB n: BITSOUT[INST[5:0]]<=1.
  - 03 CLRB n: BITSOUT[INST[5:0]]<=0.
  - 04 RTI: PC<=IPC, LEVEL<=ILEVEL, Z<=IZ, in_isr<=0.
  - 05 LEVEL n: LEVEL<=INST[3:0].
  - 06 SKBS n: skip the next instruction if BITSIN[n]=1.
  - 07 SKBC n: skip the next instruction if BITSIN[n]=0.
  - Other codes are NOP.
- op1 LDK: ADRS={12'b0,a}, CONST_RD=1, R[r]<=DATAIN.
- op2 jump group, target INST[11:0]:
  - sub0 JMP.
  - sub1 JZ (taken if Z=1).
  - sub2 JNZ (taken if Z=0).
  - Other sub codes are NOP.
- op3 ALU register form: R[r]<=R[r] OP R[a].
- op7 ALU immediate form: R[r]<=R[r] OP zero-extended a.
- ALU OP by sub: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL1, 7 SHR1.
  - Results wrap modulo 2^18.
  - Z<=(result==0).
  - 0o710106 = ADD R6,#1.
- op4 LD: ADRS=R[a], R[r]<=DATAIN.
- op5 ST: ADRS=R[a], DATAOUT=R[r], RAM_WR=1.
- op6 port group:
  - sub0 IN: ADRS=R[a], PORT_RD=1, R[r]<=DATAIN.
  - sub1 OUT: ADRS=R[a], DATAOUT=R[r], PORT_WR=1.
- Default PC<=PC+1, wrapping 4095 to 0. A skip adds 2.
- Interrupt taken on an edge when VECTOR!=0, VECTOR>LEVEL and in_isr=0:
  - The instruction at PC is not executed.
  - IPC<=PC, ILEVEL<=LEVEL, IZ<=Z.
  - LEVEL<=VECTOR, in_isr<=1, halted<=0.
  - PC<={8'b0,VECTOR}; vector 8 enters at 0o0010.
- No nesting: VECTOR is ignored while in_isr=1.
- While halted, INST is ignored and all strobes are 0.
- VECTOR is sampled at the edge only; a request removed before the edge is lost.

Optional Feature:
- BIT_IO_EN defined: BITSOUT register and SETB/CLRB/SKBS/SKBC are implemented.
- BIT_IO_EN undefined: BITSOUT is tied to 0, BITSIN is unused, and these four instructions act as NOP.

Test Plan:
- Reset/RUN: RST pulse, then RUN=0 for 2 clocks -> PC=0, RESET=1, all strobes 0. RUN=1 -> PC increments each clock.
- Interrupt during HALT. Program:
  - 0: LEVEL 3; 1: JMP 0o500.
  - 0o500: ADD R7,#1; 0o501: LEVEL 5; 0o502: HALT; 0o503: JMP 0o502.
  - 0o10: ADD R6,#1; 0o11: RTI.
  - VECTOR=8 for 2 clocks after the halt.
  - Required: PC sequence 0, 1, 0o500, 0o501, 0o502, 0o503 (held), then 0o10, 0o11, 0o503, 0o502, then held at 0o503; R6=1, R7=1, LEVEL=5 after RTI.
- Masking: LEVEL 9, VECTOR=8 -> not taken. VECTOR=10 -> PC=0o12 and IPC equals the un-executed PC.
- Memory: ST R1,[R2] with R1=0o123, R2=3 -> RAM_WR=1, ADRS=3, DATAOUT=0o123. LD R4,[R2] -> R4=0o123.
- ALU/Z: MOV R1,#0 then JZ 0o40 -> PC=0o40. ADD of 0o777777+1 -> 0, Z=1.
- Bits (BIT_IO_EN): SETB 63 -> BITSOUT[63]=1. SKBS 63 with loopback -> PC+2. CLRB 63 -> 0.

Source files
------------

// File: rtl/core18_cpu_if.sv
// core18_cpu bus interface: instruction fetch, data bus, interrupt request and bit I/O.
// Signals:
//   run     - 1 = execute, 0 = hold core idle
//   inst    - instruction at pc (combinational ROM)
//   vector  - interrupt request, 0 = none
//   datain  - read data from RAM / constant ROM / port
//   bitsin  - testable input bits
//   bitsout - bit-output register
//   const_rd, port_rd, port_wr, ram_wr - data bus strobes
//   reset   - peripheral reset
//   dataout - write data
//   adrs    - data address
//   pc      - program counter
// Modport master is the core side; slave is the system side.
interface core18_cpu_if;
  logic        run;
  logic [17:0] inst;
  logic [3:0]  vector;
  logic [17:0] datain;
  logic [63:0] bitsin;
  logic [63:0] bitsout;
  logic        const_rd;
  logic        port_rd;
  logic        port_wr;
  logic        ram_wr;
  logic        reset;
  logic [17:0] dataout;
  logic [17:0] adrs;
  logic [11:0] pc;

  modport master (
    input  run, inst, vector, datain, bitsin,
    output bitsout, const_rd, port_rd, port_wr, ram_wr, reset, dataout, adrs, pc
  );

  modport slave (
    output run, inst, vector, datain, bitsin,
    input  bitsout, const_rd, port_rd, port_wr, ram_wr, reset, dataout, adrs, pc
  );
endinterface

// File: rtl/core18_cpu.sv
// core18_cpu: 18-bit single-issue microcontroller core, one instruction per clock.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - core18_cpu_if.master (fetch, data bus, interrupts, bit I/O)
// Optional feature macro BIT_IO_EN: when defined, the bitsout register and the
// SETB/CLRB/SKBS/SKBC instructions exist; otherwise bitsout is 0, bitsin is
// ignored and those instructions behave as NOP.
module core18_cpu #(
  parameter int unsigned NREG = 64
) (
  input logic          clk,
  input logic          rst,
  core18_cpu_if.master bus
);

  logic [17:0] regs [NREG];

  logic [11:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [3:0]  level_q, level_d, ilevel_q, ilevel_d;
  logic        z_q, z_d, iz_q, iz_d;
  logic        halted_q, halted_d, in_isr_q, in_isr_d;

  logic [2:0]  op, sub;
  logic [5:0]  fa, fr;
  logic [17:0] ra, rr, alu_b, alu_res, reg_wdata;
  logic        reg_we, take, exec, skip_bit;

  assign op  = bus.inst[17:15];
  assign sub = bus.inst[14:12];
  assign fa  = bus.inst[11:6];
  assign fr  = bus.inst[5:0];
  assign ra  = regs[fa];
  assign rr  = regs[fr];

  // Interrupt pre-empts the instruction at pc; no nesting while in an ISR.
  assign take = bus.run & ~rst & (bus.vector != 4'd0) & (bus.vector > level_q) & ~in_isr_q;
  assign exec = bus.run & ~rst & ~halted_q & ~take;

`ifdef BIT_IO_EN
  logic [63:0] bits_q, bits_d;
  assign skip_bit    = bus.bitsin[fr];
  assign bus.bitsout = bits_q;
`else
  logic unused_bitsin;
  assign unused_bitsin = ^bus.bitsin;
  assign skip_bit      = 1'b0;
  assign bus.bitsout   = '0;
`endif

  // ALU: register form (op3) uses R[a], immediate form (op7) uses zero-extended a.
  assign alu_b = (op == 3'd3) ? ra : {12'd0, fa};
  always_comb begin
    alu_res = alu_b;
    case (sub)
      3'd0: alu_res = alu_b;
      3'd1: alu_res = rr + alu_b;
      3'd2: alu_res = rr - alu_b;
      3'd3: alu_res = rr & alu_b;
      3'd4: alu_res = rr | alu_b;
      3'd5: alu_res = rr ^ alu_b;
      3'd6: alu_res = {rr[16:0], 1'b0};
      3'd7: alu_res = {1'b0, rr[17:1]};
      default: alu_res = alu_b;
    endcase
  end

  // Data bus outputs
  assign bus.adrs     = (op == 3'd1) ? {12'd0, fa} :
                        ((op == 3'd4) || (op == 3'd5) || (op == 3'd6)) ? ra : 18'd0;
  assign bus.dataout  = ((op == 3'd5) || ((op == 3'd6) && (sub == 3'd1))) ? rr : 18'd0;
  assign bus.const_rd = exec & (op == 3'd1);
  assign bus.ram_wr   = exec & (op == 3'd5);
  assign bus.port_rd  = exec & (op == 3'd6) & (sub == 3'd0);
  assign bus.port_wr  = exec & (op == 3'd6) & (sub == 3'd1);
  assign bus.reset    = rst | ~bus.run;
  assign bus.pc       = bus.run ? pc_q : 12'd0;

  always_comb begin
    pc_d      = pc_q;
    ipc_d     = ipc_q;
    level_d   = level_q;
    ilevel_d  = ilevel_q;
    z_d       = z_q;
    iz_d      = iz_q;
    halted_d  = halted_q;
    in_isr_d  = in_isr_q;
    reg_we    = 1'b0;
    reg_wdata = bus.datain;
`ifdef BIT_IO_EN
    bits_d    = bits_q;
`endif
    if (!bus.run) begin
      pc_d = 12'd0;
    end else if (take) begin
      ipc_d    = pc_q;
      ilevel_d = level_q;
      iz_d     = z_q;
      level_d  = bus.vector;
      in_isr_d = 1'b1;
      halted_d = 1'b0;
      pc_d     = {8'd0, bus.vector};
    end else if (!halted_q) begin
      pc_d = pc_q + 12'd1;
      case (op)
        3'd0: begin
          case (fa)
            6'd1: halted_d = 1'b1;
`ifdef BIT_IO_EN
            6'd2: bits_d[fr] = 1'b1;
            6'd3: bits_d[fr] = 1'b0;
`endif
            6'd4: begin
              pc_d     = ipc_q;
              level_d  = ilevel_q;
              z_d      = iz_q;
              in_isr_d = 1'b0;
            end
            6'd5: level_d = bus.inst[3:0];
            6'd6: if (skip_bit) pc_d = pc_q + 12'd2;
            6'd7: if (!skip_bit && (`ifdef BIT_IO_EN 1'b1 `else 1'b0 `endif)) pc_d = pc_q + 12'd2;
            default: ;
          endcase
        end
        3'd1: reg_we = 1'b1;
        3'd2: begin
          case (sub)
            3'd0: pc_d = bus.inst[11:0];
            3'd1: if (z_q) pc_d = bus.inst[11:0];
            3'd2: if (!z_q) pc_d = bus.inst[11:0];
            default: ;
          endcase
        end
        3'd3, 3'd7: begin
          reg_we    = 1'b1;
          reg_wdata = alu_res;
          z_d       = (alu_res == 18'd0);
        end
        3'd4: reg_we = 1'b1;
        3'd6: reg_we = (sub == 3'd0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      ipc_q    <= '0;
      level_q  <= '0;
      ilevel_q <= '0;
      z_q      <= 1'b0;
      iz_q     <= 1'b0;
      halted_q <= 1'b0;
      in_isr_q <= 1'b0;
`ifdef BIT_IO_EN
      bits_q   <= '0;
`endif
    end else begin
      pc_q     <= pc_d;
      ipc_q    <= ipc_d;
      level_q  <= level_d;
      ilevel_q <= ilevel_d;
      z_q      <= z_d;
      iz_q     <= iz_d;
      halted_q <= halted_d;
      in_isr_q <= in_isr_d;
`ifdef BIT_IO_EN
      bits_q   <= bits_d;
`endif
    end
  end

  // Register file is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reg_we) regs[fr] <= reg_wdata;
  end

endmodule

// File: tb/tb_core18_cpu.sv
// Testbench for core18_cpu: directed programs plus random instruction streams,
// checked every cycle against an instruction-level reference model.
module tb_core18_cpu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core18_cpu_if bus ();
  core18_cpu dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef BIT_IO_EN
  localparam bit BitIo = 1'b1;
`else
  localparam bit BitIo = 1'b0;
`endif

  // System environment: instruction ROM, constant ROM, RAM, ports
  logic [17:0] rom  [4096];
  logic [17:0] crom [64];
  logic [17:0] ram  [256];
  logic [63:0] rand_bits;
  logic        loop;

  assign bus.inst   = rom[bus.pc];
  assign bus.datain = bus.const_rd ? crom[bus.adrs[5:0]] :
                      bus.port_rd  ? (bus.adrs ^ 18'o252525) : ram[bus.adrs[7:0]];
  assign bus.bitsin = loop ? bus.bitsout : rand_bits;

  always @(posedge clk) if (bus.ram_wr) ram[bus.adrs[7:0]] <= bus.dataout;

  // Reference model state
  logic [17:0] m_r   [64];
  logic [17:0] m_ram [256];
  logic [11:0] m_pc, m_ipc;
  logic [3:0]  m_level, m_ilevel;
  logic        m_z, m_iz, m_halt, m_isr;
  logic [63:0] m_bits;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] e_sys(input int code, input int n);
    logic [5:0] c = 6'(code);
    logic [5:0] v = 6'(n);
    return {6'd0, c, v};
  endfunction
  function automatic logic [17:0] e_op(input logic [2:0] o, input logic [2:0] s,
                                       input int a, input int r);
    logic [5:0] av = 6'(a);
    logic [5:0] rv = 6'(r);
    return {o, s, av, rv};
  endfunction
  function automatic logic [17:0] e_jmp(input logic [2:0] s, input int t);
    logic [11:0] tv = 12'(t);
    return {3'd2, s, tv};
  endfunction

  function automatic logic [17:0] ref_alu(input logic [2:0] s, input logic [17:0] x,
                                          input logic [17:0] y);
    int unsigned m = 262144;
    int unsigned xi = x;
    int unsigned yi = y;
    int unsigned res;
    case (s)
      3'd0: res = yi;
      3'd1: res = (xi + yi) % m;
      3'd2: res = (xi + m - yi) % m;
      3'd3: res = xi & yi;
      3'd4: res = xi | yi;
      3'd5: res = xi ^ yi;
      3'd6: res = (xi * 2) % m;
      default: res = xi / 2;
    endcase
    return 18'(res);
  endfunction

  function automatic logic [17:0] rand_inst();
    logic [17:0] i = 18'($urandom);
    case (i[17:15])
      3'd0: begin
        i[11:6] = 6'($urandom_range(0, 9));
        if (i[11:6] == 6'd1 && $urandom_range(0, 3) != 0) i[11:6] = 6'd0;
      end
      3'd2: ;
      3'd1, 3'd7: i[5:3] = 3'd0;
      default: begin
        i[5:3]  = 3'd0;
        i[11:9] = 3'd0;
      end
    endcase
    return i;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ipc = '0; m_level = '0; m_ilevel = '0;
    m_z = 0; m_iz = 0; m_halt = 0; m_isr = 0; m_bits = '0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 18'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pc", 64'(bus.pc), 64'd0);
    chk("rst_reset_out", 64'(bus.reset), 64'd1);
    chk("rst_strobes", 64'({bus.const_rd, bus.port_rd, bus.port_wr, bus.ram_wr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Check the DUT outputs for this cycle against the model, then advance one clock.
  // exp_pc >= 0 additionally checks pc against a fixed value.
  task automatic step(input int exp_pc);
    logic [11:0] e_pc, nxt;
    logic [17:0] ins, ra, rr, res;
    logic [2:0]  op, sub;
    logic [5:0]  a, r;
    logic [63:0] bin;
    logic        take, ex;
    logic [3:0]  e_str;
    #1;
    e_pc = bus.run ? m_pc : 12'd0;
    ins  = rom[e_pc];
    op = ins[17:15]; sub = ins[14:12]; a = ins[11:6]; r = ins[5:0];
    ra = m_r[a]; rr = m_r[r];
    bin  = loop ? m_bits : rand_bits;
    take = bus.run && bus.vector != 0 && bus.vector > m_level && !m_isr;
    ex   = bus.run && !take && !m_halt;
    e_str = {ex && op == 3'd1, ex && op == 3'd6 && sub == 3'd0,
             ex && op == 3'd6 && sub == 3'd1, ex && op == 3'd5};
    chk("pc", 64'(bus.pc), 64'(e_pc));
    if (exp_pc >= 0) chk("pc_fixed", 64'(bus.pc), 64'(exp_pc));
    chk("strobes", 64'({bus.const_rd, bus.port_rd, bus.port_wr, bus.ram_wr}), 64'(e_str));
    chk("reset_out", 64'(bus.reset), 64'(!bus.run));
    chk("bitsout", bus.bitsout, m_bits);
    if (e_str != 0) chk("adrs", 64'(bus.adrs), 64'((op == 3'd1) ? {12'd0, a} : ra));
    if (e_str[1] || e_str[0]) chk("dataout", 64'(bus.dataout), 64'(rr));
    @(posedge clk);
    if (!bus.run) begin
      m_pc = 12'd0;
    end else if (take) begin
      m_ipc = m_pc; m_ilevel = m_level; m_iz = m_z;
      m_level = bus.vector; m_isr = 1; m_halt = 0;
      m_pc = {8'd0, bus.vector};
    end else if (!m_halt) begin
      nxt = m_pc + 12'd1;
      case (op)
        3'd0: begin
          if (a == 6'd1) m_halt = 1;
          if (a == 6'd2 && BitIo) m_bits[r] = 1'b1;
          if (a == 6'd3 && BitIo) m_bits[r] = 1'b0;
          if (a == 6'd4) begin
            nxt = m_ipc; m_level = m_ilevel; m_z = m_iz; m_isr = 0;
          end
          if (a == 6'd5) m_level = ins[3:0];
          if (a == 6'd6 && BitIo && bin[r]) nxt = m_pc + 12'd2;
          if (a == 6'd7 && BitIo && !bin[r]) nxt = m_pc + 12'd2;
        end
        3'd1: m_r[r] = crom[a];
        3'd2: if (sub == 0 || (sub == 1 && m_z) || (sub == 2 && !m_z)) nxt = ins[11:0];
        3'd3, 3'd7: begin
          res = ref_alu(sub, rr, (op == 3'd3) ? ra : {12'd0, a});
          m_r[r] = res;
          m_z = (res == 0);
        end
        3'd4: m_r[r] = m_ram[ra[7:0]];
        3'd5: m_ram[ra[7:0]] = rr;
        default: if (sub == 0) m_r[r] = ra ^ 18'o252525;
      endcase
      m_pc = nxt;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.run = 1'b1; bus.vector = 4'd0; loop = 1'b0; rand_bits = '0;
    for (int i = 0; i < 64; i++) begin crom[i] = 18'($urandom); m_r[i] = '0; end
    for (int i = 0; i < 256; i++) begin ram[i] = 18'(i * 7); m_ram[i] = 18'(i * 7); end
    // Clear every register through the ISA (registers have no reset)
    clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = e_op(3'd7, 3'd0, 0, i);
    do_reset();
    for (int i = 0; i < 64; i++) step(i);

    // Reset / RUN
    clear_rom();
    rom[0] = e_op(3'd5, 3'd0, 0, 0);
    bus.run = 1'b0;
    do_reset();
    step(0); step(0);
    #1;
    chk("run0_reset_out", 64'(bus.reset), 64'd1);
    chk("run0_strobes", 64'({bus.const_rd, bus.port_rd, bus.port_wr, bus.ram_wr}), 64'd0);
    @(negedge clk);
    bus.run = 1'b1;
    step(0); step(1); step(2); step(3);

    // Interrupt during HALT
    clear_rom();
    rom[0] = e_sys(5, 3);               rom[1] = e_jmp(3'd0, 'o500);
    rom['o500] = e_op(3'd7, 3'd1, 1, 7); rom['o501] = e_sys(5, 5);
    rom['o502] = e_sys(1, 0);           rom['o503] = e_jmp(3'd0, 'o502);
    rom['o10] = e_op(3'd7, 3'd1, 1, 6);  rom['o11] = e_sys(4, 0);
    do_reset();
    step(0); step(1); step('o500); step('o501); step('o502); step('o503); step('o503);
    bus.vector = 4'd8;
    step('o503); step('o10);
    bus.vector = 4'd0;
    step('o11); step('o503); step('o502); step('o503); step('o503);
    chk("halt_r6", 64'(dut.regs[6]), 64'd1);
    chk("halt_r7", 64'(dut.regs[7]), 64'd1);
    chk("halt_level", 64'(dut.level_q), 64'd5);

    // Masking
    clear_rom();
    rom[0] = e_sys(5, 9);
    do_reset();
    step(0);
    bus.vector = 4'd8;
    step(1); step(2);
    bus.vector = 4'd10;
    step(3);
    bus.vector = 4'd0;
    step('o12);
    chk("mask_ipc", 64'(dut.ipc_q), 64'd3);
    chk("mask_level", 64'(dut.level_q), 64'd10);

    // Memory
    clear_rom();
    crom[5] = 18'o123;
    rom[0] = e_op(3'd1, 3'd0, 5, 1); rom[1] = e_op(3'd7, 3'd0, 3, 2);
    rom[2] = e_op(3'd5, 3'd0, 2, 1); rom[3] = e_op(3'd4, 3'd0, 2, 4);
    rom[4] = e_op(3'd6, 3'd1, 2, 4); rom[5] = e_op(3'd6, 3'd0, 1, 5);
    do_reset();
    step(0); step(1);
    #1;
    chk("st_ram_wr", 64'(bus.ram_wr), 64'd1);
    chk("st_adrs", 64'(bus.adrs), 64'd3);
    chk("st_dataout", 64'(bus.dataout), 64'o123);
    step(2); step(3);
    chk("ld_r4", 64'(dut.regs[4]), 64'o123);
    step(4); step(5); step(6);

    // ALU / Z
    clear_rom();
    crom[6] = 18'o777777;
    rom[0] = e_op(3'd1, 3'd0, 6, 3); rom[1] = e_op(3'd7, 3'd0, 0, 1);
    rom[2] = e_jmp(3'd1, 'o40);      rom['o40] = e_op(3'd7, 3'd1, 1, 3);
    rom['o41] = e_jmp(3'd2, 'o100);
    do_reset();
    step(0); step(1); step(2); step('o40);
    chk("wrap_r3", 64'(dut.regs[3]), 64'd0);
    chk("wrap_z", 64'(dut.z_q), 64'd1);
    step('o41); step('o42);

    // Bit I/O with loopback
    clear_rom();
    rom[0] = e_sys(2, 63); rom[1] = e_sys(6, 63); rom[3] = e_sys(3, 63); rom[4] = e_sys(6, 63);
    loop = 1'b1;
    do_reset();
    step(0); step(1);
    chk("setb63", 64'(bus.bitsout[63]), 64'(BitIo));
`ifndef BIT_IO_EN
    step(2);
`endif
    step(3);
    chk("clrb63", 64'(bus.bitsout[63]), 64'd0);
    step(4); step(5);
    loop = 1'b0;

    // Random instruction streams
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 4096; i++) rom[i] = rand_inst();
      do_reset();
      for (int c = 0; c < 300; c++) begin
        bus.run    = ($urandom_range(0, 31) != 0);
        bus.vector = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
        rand_bits  = {$urandom, $urandom};
        step(-1);
      end
      bus.run = 1'b1; bus.vector = 4'd0;
      for (int i = 0; i < 8; i++) chk("rand_reg", 64'(dut.regs[i]), 64'(m_r[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
